// File: rtl/seg7_ctrl_pkg.sv
// Shared register map, CTRL field positions and divider defaults for the
// seven-segment control stage.
package seg7_ctrl_pkg;

    typedef enum logic [1:0] {
        ADDR_DATA   = 2'd0,
        ADDR_CTRL   = 2'd1,
        ADDR_STATUS = 2'd2,
        ADDR_RSVD   = 2'd3
    } reg_addr_e;

    localparam int CTRL_POINT_LSB    = 0;
    localparam int CTRL_EN_LSB       = 8;
    localparam int CTRL_BLINK_EN_BIT = 16;
    localparam int STATUS_PHASE_BIT  = 16;

    localparam int SCAN_DIV_DEFAULT  = 50000;
    localparam int BLINK_DIV_DEFAULT = 500;

    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++)
            if (be[i]) res[i*8 +: 8] = new_v[i*8 +: 8];
        return res;
    endfunction

endpackage

// File: rtl/seg7_clkgen.sv
// Scan clock divider with commit strobe (the scan_clk falling edge) and the
// blink half-period counter that advances once per commit.
module seg7_clkgen #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 500
) (
    input  logic clk,
    input  logic rst_n,
    output logic scan_clk,
    output logic commit,
    output logic blink_phase
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] HALF_LAST  = CW'(SCAN_DIV / 2 - 1);
    localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [CW-1:0] scan_cnt;
    logic [BW-1:0] blink_cnt;

    // High on the cycle whose closing edge drops scan_clk.
    assign commit = (scan_cnt == SCAN_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt    <= '0;
            scan_clk    <= 1'b0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            scan_cnt <= commit ? '0 : scan_cnt + CW'(1);
            if (commit || scan_cnt == HALF_LAST)
                scan_clk <= ~scan_clk;
            if (commit) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + BW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/seg7_ctrl.sv
// Bus-facing register block for the 8-digit scanner: CPU shadow registers,
// plus output registers that only change on the scan_clk falling edge.
module seg7_ctrl
    import seg7_ctrl_pkg::*;
#(
    parameter int DIGITS    = 8,
    parameter int SCAN_DIV  = SCAN_DIV_DEFAULT,
    parameter int BLINK_DIV = BLINK_DIV_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic                  we,
    input  logic [1:0]            addr,
    input  logic [31:0]           wdata,
    input  logic [3:0]            be,
    output logic                  ack,
    output logic [31:0]           rdata,
    output logic                  scan_clk,
    output logic [DIGITS*4-1:0]   data,
    output logic [DIGITS-1:0]     point,
    output logic [DIGITS-1:0]     en,
    output logic                  blink
);

    logic                commit;
    logic                blink_phase;
    logic [DIGITS*4-1:0] sh_data;
    logic [DIGITS-1:0]   sh_point;
    logic [DIGITS-1:0]   sh_en;
    logic                sh_blink_en;
    logic [15:0]         frame_cnt;
    logic [2:0]          digit_cnt;
    logic [31:0]         rd_mux;

    seg7_clkgen #(
        .SCAN_DIV  (SCAN_DIV),
        .BLINK_DIV (BLINK_DIV)
    ) u_clkgen (
        .clk         (clk),
        .rst_n       (rst_n),
        .scan_clk    (scan_clk),
        .commit      (commit),
        .blink_phase (blink_phase)
    );

    always_comb begin
        rd_mux = '0;
        case (reg_addr_e'(addr))
            ADDR_DATA:   rd_mux = sh_data;
            ADDR_CTRL:   rd_mux = {15'b0, sh_blink_en, sh_en, sh_point};
            ADDR_STATUS: rd_mux = {15'b0, blink_phase, frame_cnt};
            default:     rd_mux = '0;
        endcase
    end

    // Handshake: a req sampled on one edge is answered by ack on the next
    // cycle for exactly one cycle, no backpressure; rdata carries the
    // pre-edge register value with that ack and is 0 otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack         <= 1'b0;
            rdata       <= '0;
            sh_data     <= '0;
            sh_point    <= '0;
            sh_en       <= '0;
            sh_blink_en <= 1'b0;
            data        <= '0;
            point       <= '0;
            en          <= '0;
            blink       <= 1'b0;
            frame_cnt   <= '0;
            digit_cnt   <= '0;
        end else begin
            ack   <= req;
            rdata <= '0;
            if (req && we) begin
                case (reg_addr_e'(addr))
                    ADDR_DATA: sh_data <= be_merge(sh_data, wdata, be);
                    ADDR_CTRL: begin
                        if (be[0]) sh_point    <= wdata[CTRL_POINT_LSB +: 8];
                        if (be[1]) sh_en       <= wdata[CTRL_EN_LSB +: 8];
                        if (be[2]) sh_blink_en <= wdata[CTRL_BLINK_EN_BIT];
                    end
                    default: ;
                endcase
            end else if (req) begin
                rdata <= rd_mux;
            end
            // Commit copies the pre-write shadow; a same-cycle write waits a period.
            if (commit) begin
                data      <= sh_data;
                point     <= sh_point;
                en        <= sh_en;
                blink     <= blink_phase & sh_blink_en;
                digit_cnt <= digit_cnt + 3'd1;
                if (digit_cnt == 3'(DIGITS - 1))
                    frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_ctrl.sv
// Randomized self-checking bench for seg7_ctrl against a timeline-based
// reference model (edge count since reset release drives all expectations).
module tb_seg7_ctrl;

    localparam int SD = 4;
    localparam int BD = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;
    logic        ack;
    logic [31:0] rdata;
    logic        scan_clk;
    logic [31:0] data;
    logic [7:0]  point;
    logic [7:0]  en;
    logic        blink;

    seg7_ctrl #(.DIGITS(8), .SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .be       (be),
        .ack      (ack),
        .rdata    (rdata),
        .scan_clk (scan_clk),
        .data     (data),
        .point    (point),
        .en       (en),
        .blink    (blink)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: shadow registers, committed outputs, edges since release.
    int          t;
    logic [31:0] m_data;
    logic [7:0]  m_point, m_en;
    logic        m_ben;
    logic [31:0] o_data;
    logic [7:0]  o_point, o_en;
    logic        o_blink;
    logic        exp_ack;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0d)", tag, got, exp, t);
        end
    endtask

    task automatic model_reset();
        t = 0;
        m_data = '0; m_point = '0; m_en = '0; m_ben = 1'b0;
        o_data = '0; o_point = '0; o_en = '0; o_blink = 1'b0;
        exp_ack = 1'b0;
        exp_q.delete();
    endtask

    // One clock cycle with the currently driven inputs, then full output check.
    task automatic step();
        logic [31:0] rexp;
        int k;
        rexp = '0;
        if (req && !we) begin
            k = t / SD;
            case (addr)
                2'd0: rexp = m_data;
                2'd1: rexp = {15'b0, m_ben, m_en, m_point};
                2'd2: rexp = {15'b0, 1'((k / BD) % 2), 16'(k / 8)};
                default: rexp = '0;
            endcase
            exp_q.push_back(rexp);
        end
        exp_ack = req;
        @(posedge clk);
        t++;
        if (t % SD == 0) begin
            k = t / SD;
            o_data  = m_data;
            o_point = m_point;
            o_en    = m_en;
            o_blink = (((k - 1) / BD) % 2 == 1) && m_ben;
        end
        if (req && we) begin
            if (addr == 2'd0) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) m_data[i*8 +: 8] = wdata[i*8 +: 8];
            end else if (addr == 2'd1) begin
                if (be[0]) m_point = wdata[7:0];
                if (be[1]) m_en    = wdata[15:8];
                if (be[2]) m_ben   = wdata[16];
            end
        end
        #1;
        check("ack", ack, exp_ack);
        if (ack && exp_q.size() > 0) check("rdata", rdata, exp_q.pop_front());
        else check("rdata_idle", rdata, 32'd0);
        check("scan_clk", scan_clk, ((t % SD) >= SD / 2) ? 1 : 0);
        check("data", data, o_data);
        check("point", point, o_point);
        check("en", en, o_en);
        check("blink", blink, o_blink);
    endtask

    task automatic drive(input logic w, input logic [1:0] a, input logic [31:0] d, input logic [3:0] b);
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        step();
        req = 1'b0; we = 1'b0;
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        req = 1'b0; we = 1'b0;
        rst_n = 1'b0;
        #2;
        check("rst_ack", ack, 0);
        check("rst_rdata", rdata, 0);
        check("rst_scan_clk", scan_clk, 0);
        check("rst_data", data, 0);
        check("rst_point", point, 0);
        check("rst_en", en, 0);
        check("rst_blink", blink, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic random_run(input int n);
        for (int i = 0; i < n; i++) begin
            req   = ($urandom_range(0, 2) != 0);
            we    = $urandom_range(0, 1);
            addr  = 2'($urandom_range(0, 3));
            wdata = $urandom;
            be    = 4'($urandom_range(0, 15));
            step();
        end
        req = 1'b0;
    endtask

    initial begin
        model_reset();
        #12;
        do_reset();
        idle(10);

        drive(1'b1, 2'd0, 32'h1234_5678, 4'hF);
        idle(SD + 2);
        drive(1'b0, 2'd0, 32'h0, 4'h0);
        drive(1'b1, 2'd0, 32'hFFFF_FFFF, 4'h5);
        drive(1'b0, 2'd0, 32'h0, 4'h0);
        check("data_be_merge", m_data, 32'h12FF_56FF);

        drive(1'b1, 2'd1, 32'h0001_0F81, 4'hF);
        drive(1'b0, 2'd1, 32'h0, 4'h0);
        idle(SD * BD * 6);
        drive(1'b1, 2'd1, 32'h0000_0000, 4'h4);
        idle(SD * 3);

        req = 1'b1;
        we = 1'b1; addr = 2'd0; wdata = 32'hCAFE_F00D; be = 4'hF; step();
        we = 1'b0; addr = 2'd0; step();
        we = 1'b0; addr = 2'd2; step();
        req = 1'b0;
        idle(2);

        while ((t + 1) % SD != 0) idle(1);
        drive(1'b1, 2'd0, 32'hA5A5_5A5A, 4'hF);
        idle(SD * 2 + 1);

        random_run(3000);
        idle(5);
        do_reset();
        idle(6);
        random_run(600);
        idle(4);

        check("pending_reads", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seg7_ctrl.md
Name: seg7_ctrl

Overview:
- Bus-facing control stage that sits directly upstream of the 8-digit seven-segment scanner.
- Holds the CPU-written digit data, decimal points, digit enables and blink control.
- Generates the scanner's scan clock and blink signal.
- Updates scanner-side outputs only at a safe scan-clock phase, so the scanner never samples a torn value.

Parameters:
- DIGITS, 8, number of digits (fixed 8 for register layout; other values unsupported).
- SCAN_DIV, 50000, clk cycles per scan_clk period; must be even and ≥4.
- BLINK_DIV, 500, scan_clk periods per blink half-period; ≥1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  bus request; one-cycle strobe.
- we  in  1  1 = write, 0 = read.
- addr  in  2  register select.
- wdata  in  32  write data.
- be  in  4  byte enables for writes.
- ack  out  1  one-cycle completion pulse.
- rdata  out  32  read data; valid only while ack = 1.
- scan_clk  out  1  scan clock to scanner, 50% duty.
- data  out  DIGITS*4  digit nibbles; digit 0 = bits 3:0.
- point  out  DIGITS  decimal-point bits.
- en  out  DIGITS  digit enables.
- blink  out  1  blink level to scanner.

Behaviour:
- Reset (async assert, sync release): all shadow and output registers clear to 0. This includes data, point, en, ack, rdata, the scan counter, scan_clk, the blink counter and the blink phase. blink is also 0.
- Register map:
  - addr 0 DATA (R/W): 32-bit digit nibbles, byte-enable writes.
  - addr 1 CTRL (R/W):
    - bits 7:0 point.
    - bits 15:8 en.
    - bit 16 blink_en.
    - bits 31:17 read 0, writes ignored.
    - be[0] covers point, be[1] covers en, be[2] covers blink_en.
  - addr 2 STATUS (RO): bits 15:0 frame counter, bit 16 blink phase, rest 0. Writes are acked and ignored.
  - addr 3: reserved, reads 0, writes ignored and acked.
- Bus handshake:
  - req sampled at cycle N produces ack = 1 at cycle N+1 for exactly one cycle.
  - Reads return the shadow value as it was at cycle N.
  - Writes update the shadow at the N→N+1 edge.
  - req asserted in consecutive cycles is legal; each request gets its own ack (back-to-back throughput 1/cycle).
  - rdata holds 0 when ack = 0.
- Scan divider:
  - Counter runs 0..SCAN_DIV-1 and wraps.
  - scan_clk toggles at count = SCAN_DIV/2-1 and at count = SCAN_DIV-1.
- Commit point: on the clk edge where scan_clk goes 1→0, shadow DATA/point/en are copied to the data/point/en outputs. Outputs are therefore stable for ≥ SCAN_DIV/2 clk around every scan_clk rising edge.
- Write on the same cycle as the commit: the commit uses the pre-write shadow; the new value appears at the next commit.
- Frame counter: increments at every DIGITS-th commit, wraps 0xFFFF→0.
- Blink:
  - Counter increments once per commit; at count = BLINK_DIV-1 it clears and the blink phase toggles.
  - blink = blink_phase & blink_en, registered and updated at the commit point.
  - blink_en = 0 holds blink at 0 but the phase keeps running.
- Reset mid-operation clears everything immediately. After release, the first scan_clk rise occurs SCAN_DIV/2 clk later.

Decomposition:
- Shared package holds:
  - address constants ADDR_DATA = 0, ADDR_CTRL = 1, ADDR_STATUS = 2.
  - CTRL bit positions.
  - default SCAN_DIV and BLINK_DIV.
- One natural sub-module: seg7_clkgen. It contains the scan divider, commit strobe, blink counter and phase. It outputs scan_clk, a commit pulse and blink_phase.
- Bus decode, shadow registers and output registers stay in seg7_ctrl.

Test Plan:
- Reset, then observe with SCAN_DIV = 4 → scan_clk reads 0,0,1,1,0,0,… after release; data/point/en/blink = 0; ack never pulses without req.
- Write DATA = 0x12345678, be = 0xF at cycle N → ack at N+1; data output stays 0 until the next scan_clk 1→0, then shows 0x12345678. Read DATA → ack with rdata = 0x12345678.
- Write DATA = 0xFFFFFFFF with be = 0x5 over 0x12345678 → DATA reads 0x12FF56FF.
- Write CTRL = 0x0001_0F81 with BLINK_DIV = 2 → point = 0x81, en = 0x0F after commit; blink toggles every 2 scan periods. Clear bit 16 → blink = 0 from the next commit.
- req held high 3 cycles (write DATA, read DATA, read STATUS) → 3 consecutive ack pulses. The second read returns the newly written value.
- Write issued exactly on the commit cycle → output keeps the old value for one scan period, then takes the new value. After 8·65536 commits the frame counter reads 0.
